centroid_packer: RTL

CENTROID_PACKER -- requirements
Module: centroid_packer

---
 rtl/centroid_packer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/centroid_packer.sv
// Packs a cluster-major stream of centroid dimension words into 512-bit lines, one centroid per line group.
// Latency: a line is presented one cycle after its final word is accepted; pass_done follows the last line by one cycle.
// Backpressure: in_ready is high only while packing; there is no downstream backpressure, so each line is presented for exactly one cycle.
// Optional macro CENTROID_PACKER_DEBUG_EN adds output dbg_line_cnt, a count of emitted lines cleared by start.
`timescale 1ns/1ps

module centroid_packer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        num_cluster,
    input  logic [15:0]       num_dim,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [511:0]      update,
    output logic              update_valid,
    output logic              update_last,
    output logic              pass_done
`ifdef CENTROID_PACKER_DEBUG_EN
    ,
    output logic [31:0]       dbg_line_cnt
`endif
);

    localparam int WPL    = 512 / DATA_W;
    localparam int SLOT_W = $clog2(WPL);
    localparam int LOG_DW = $clog2(DATA_W);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(WPL - 1);

    typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

    state_t              state_q, state_d;
    logic [7:0]          ncl_q, ncl_d;
    logic [15:0]         ndim_q, ndim_d;
    logic [15:0]         dim_q, dim_d;
    logic [7:0]          cl_q, cl_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [511:0]        line_q, line_d;
    logic [511:0]        update_q, update_d;
    logic                update_valid_q, update_valid_d;
    logic                update_last_q, update_last_d;
    logic                pass_done_q, pass_done_d;
    logic                in_ready_q, in_ready_d;

    logic                accept;
    logic                dim_last;
    logic                cl_last;
    logic                line_end;
    logic [511:0]        line_upd;

    assign accept   = in_valid & in_ready_q;
    assign dim_last = (dim_q == ndim_q - 16'd1);
    assign cl_last  = (cl_q == ncl_q - 8'd1);
    assign line_end = dim_last | (slot_q == SLOT_MAX);

    // Next-state logic: pass sequencing, word placement and line emission
    always_comb begin
        state_d        = state_q;
        ncl_d          = ncl_q;
        ndim_d         = ndim_q;
        dim_d          = dim_q;
        cl_d           = cl_q;
        slot_d         = slot_q;
        line_d         = line_q;
        update_d       = update_q;
        update_valid_d = 1'b0;
        update_last_d  = 1'b0;
        pass_done_d    = 1'b0;
        line_upd       = line_q;
        line_upd[{slot_q, {LOG_DW{1'b0}}} +: DATA_W] = in_data;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ncl_d  = num_cluster;
                    ndim_d = num_dim;
                    dim_d  = '0;
                    cl_d   = '0;
                    slot_d = '0;
                    line_d = '0;
                    // An empty pass still completes, it just emits no lines
                    state_d = ((num_cluster == 8'd0) || (num_dim == 16'd0)) ? DONE : PACK;
                end
            end
            PACK: begin
                if (accept) begin
                    if (line_end) begin
                        // Emit and clear together so the next word starts a zeroed line
                        update_d       = line_upd;
                        update_valid_d = 1'b1;
                        update_last_d  = dim_last & cl_last;
                        line_d         = '0;
                        slot_d         = '0;
                    end else begin
                        line_d = line_upd;
                        slot_d = slot_q + SLOT_W'(1);
                    end
                    if (dim_last) begin
                        dim_d = '0;
                        cl_d  = cl_last ? 8'd0 : cl_q + 8'd1;
                        if (cl_last) begin
                            state_d = DONE;
                        end
                    end else begin
                        dim_d = dim_q + 16'd1;
                    end
                end
            end
            DONE: begin
                pass_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == PACK);
    end

    // State, counters, line buffer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ncl_q          <= '0;
            ndim_q         <= '0;
            dim_q          <= '0;
            cl_q           <= '0;
            slot_q         <= '0;
            line_q         <= '0;
            update_q       <= '0;
            update_valid_q <= 1'b0;
            update_last_q  <= 1'b0;
            pass_done_q    <= 1'b0;
            in_ready_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ncl_q          <= ncl_d;
            ndim_q         <= ndim_d;
            dim_q          <= dim_d;
            cl_q           <= cl_d;
            slot_q         <= slot_d;
            line_q         <= line_d;
            update_q       <= update_d;
            update_valid_q <= update_valid_d;
            update_last_q  <= update_last_d;
            pass_done_q    <= pass_done_d;
            in_ready_q     <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign update       = update_q;
    assign update_valid = update_valid_q;
    assign update_last  = update_last_q;
    assign pass_done    = pass_done_q;

`ifdef CENTROID_PACKER_DEBUG_EN
    logic [31:0] dbg_cnt_q, dbg_cnt_d;

    // Line counter tracks the pulse being launched this cycle; start begins a fresh count
    always_comb begin
        dbg_cnt_d = dbg_cnt_q;
        if ((state_q == IDLE) && start) begin
            dbg_cnt_d = '0;
        end else if (update_valid_d) begin
            dbg_cnt_d = dbg_cnt_q + 32'd1;
        end
    end

    // Debug line counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_cnt_q <= '0;
        end else begin
            dbg_cnt_q <= dbg_cnt_d;
        end
    end

    assign dbg_line_cnt = dbg_cnt_q;
`endif

endmodule
